qreg_uart_tx: RTL and testbench

Synthesizable producer for the nic8 output stream. It watches the CPU's `qreg` output register and, for every change of value, transmits the new value as three zero-padded ASCII decimal digits plus a newline (`"%03d\n"`) over an 8N1 serial line. It sits beside the CPU core on the board build and gives the hardware the same text stream that simulation prints for `qreg`. A small FIFO absorbs bursts of output writes that arrive faster than the line rate.

---
 rtl/qreg_uart_tx.sv | 151 +++++++++++++++
 tb/tb_qreg_uart_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/qreg_uart_tx.sv
// Streams every change of the CPU qreg as "%03d\n" over an 8N1 line.
// A small FIFO absorbs bursts of qreg changes that arrive faster than the line rate.
module qreg_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] qreg,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [1:0]    chr_idx, chr_idx_nx;
    logic [3:0]    dig_h, dig_t, dig_o;
    logic [7:0]    cur_char;
    logic          cell_end, pop;

    logic [7:0]    prev;
    logic          push, accept, full, empty;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [NW-1:0] count;
    logic [7:0]    head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // change detect: prev clears to 0, so a zero qreg at reset release is silent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= 8'h00;
        else       prev <= qreg;
    end

    assign push   = (qreg != prev);
    assign full   = (count == NW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign accept = push && (!full || pop);
    assign head   = mem[rptr];

    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= qreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wptr <= ptr_inc(wptr);
            if (pop)    rptr <= ptr_inc(rptr);
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    // digits are latched at pop, so the FIFO head is free to change mid-frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            chr_idx <= '0;
            dig_h   <= '0;
            dig_t   <= '0;
            dig_o   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            chr_idx <= chr_idx_nx;
            if (pop) begin
                dig_h <= 4'(head / 8'd100);
                dig_t <= 4'((head / 8'd10) % 8'd10);
                dig_o <= 4'(head % 8'd10);
            end
        end
    end

    always_comb begin
        case (chr_idx)
            2'd0:    cur_char = {4'h3, dig_h};
            2'd1:    cur_char = {4'h3, dig_t};
            2'd2:    cur_char = {4'h3, dig_o};
            default: cur_char = 8'h0A;
        endcase
    end

    assign cell_end = (cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        chr_idx_nx = chr_idx;
        pop        = 1'b0;
        tx         = 1'b1;
        if (state != IDLE) cnt_nx = cell_end ? '0 : cnt + 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cnt_nx     = '0;
                    bit_idx_nx = '0;
                    chr_idx_nx = '0;
                    state_nx   = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (cell_end) state_nx = DATA;
            end
            DATA: begin
                tx = cur_char[bit_idx];
                if (cell_end) begin
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (cell_end) begin
                    if (chr_idx != 2'd3) begin
                        chr_idx_nx = chr_idx + 2'd1;
                        state_nx   = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE) || !empty;
endmodule

// File: tb/tb_qreg_uart_tx.sv
// Directed bench for qreg_uart_tx: decodes the serial line and checks text, timing and flags.
module tb_qreg_uart_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] qreg = 8'h00, qreg2 = 8'h00;
    logic       tx4, busy4, ovf4, tx2, busy2, ovf2;
    int         cyc = 0;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qreg_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .qreg(qreg), .tx(tx4), .busy(busy4), .overflow(ovf4));
    qreg_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .reset(reset), .qreg(qreg2), .tx(tx2), .busy(busy2), .overflow(ovf2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel != 0) ? tx2 : tx4;
    endfunction

    // waits for a start bit, then samples every cell centre of one 8N1 character
    task automatic recv_char(input int sel, output logic [7:0] c, output int s);
        int cpb, to, b;
        logic sok, pok;
        cpb = (sel != 0) ? 2 : 4;
        c = 8'h00; s = -1; to = 0;
        do begin
            @(negedge clk);
            to++;
        end while (get_tx(sel) !== 1'b0 && to < 500);
        if (get_tx(sel) !== 1'b0) begin
            chk("start_timeout", 1, 0);
            return;
        end
        s = cyc; sok = 1'b1; pok = 1'b0;
        for (int j = 0; j < 10 * cpb; j++) begin
            if (j > 0) @(negedge clk);
            if (j < cpb && get_tx(sel) !== 1'b0) sok = 1'b0;
            if (j % cpb == cpb / 2) begin
                b = j / cpb;
                if (b >= 1 && b <= 8) c[b-1] = get_tx(sel);
                if (b == 9) pok = get_tx(sel);
            end
        end
        chk("framing", {30'd0, sok, pok}, 32'd3);
    endtask

    task automatic recv_value(input int sel, input logic [31:0] exp, input string tag, output int s);
        logic [7:0] c;
        int st, pst, cpb;
        cpb = (sel != 0) ? 2 : 4;
        s = -1; pst = 0;
        for (int i = 0; i < 4; i++) begin
            recv_char(sel, c, st);
            if (i == 0) s = st;
            else chk({tag, "_spacing"}, st - pst, 10 * cpb);
            chk($sformatf("%s_c%0d", tag, i), {24'd0, c}, {24'd0, exp[31-8*i -: 8]});
            pst = st;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s, s1, s0, lows;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx4, 1);
        chk("rst_busy", busy4, 0);
        chk("rst_ovf", ovf4, 0);
        chk("rst_tx2", tx2, 1);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("zero_not_sent", busy4, 0);

        // 0 -> 7 : start bit right after E1, 160-cycle frame
        qreg = 8'd7; k = cyc;
        @(negedge clk);
        chk("busy_rise", busy4, 1);
        chk("idle_before_pop", tx4, 1);
        recv_value(0, 32'h3030370A, "v7", s);
        chk("v7_start_cycle", s, k + 2);
        chk("v7_busy_last", busy4, 1);
        @(negedge clk);
        chk("v7_busy_fall", busy4, 0);
        chk("v7_frame_len", cyc - s, 160);

        qreg = 8'd255; recv_value(0, 32'h3235350A, "v255", s);
        qreg = 8'd100; recv_value(0, 32'h3130300A, "v100", s);
        qreg = 8'd9;   recv_value(0, 32'h3030390A, "v9", s);
        repeat (3) @(negedge clk);
        chk("pre_burst_ovf", ovf4, 0);

        // burst 1..6 on consecutive edges: five sent, 6 dropped
        fork
            begin
                for (int v = 1; v <= 6; v++) begin
                    qreg = 8'(v);
                    @(negedge clk);
                    if (v == 5) chk("ovf_before_6th", ovf4, 0);
                end
                chk("ovf_after_6th", ovf4, 1);
            end
            begin
                s0 = 0;
                for (int v = 1; v <= 5; v++) begin
                    recv_value(0, {8'h30, 8'h30, 8'(8'h30 + v), 8'h0A}, $sformatf("burst%0d", v), s1);
                    if (v > 1) chk("burst_gap", s1 - s0, 161);
                    s0 = s1;
                end
            end
        join
        @(negedge clk);
        chk("burst_busy_fall", busy4, 0);
        chk("ovf_sticky", ovf4, 1);

        // held value is sent once
        qreg = 8'd5; recv_value(0, 32'h3030350A, "hold5", s);
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx4 !== 1'b1) lows++;
        end
        chk("hold_quiet", lows, 0);
        chk("hold_busy", busy4, 0);

        // 5 -> 6 -> 5
        qreg = 8'd6; @(negedge clk); qreg = 8'd5;
        recv_value(0, 32'h3030360A, "seq6", s0);
        recv_value(0, 32'h3030350A, "seq5", s1);
        chk("seq_gap", s1 - s0, 161);

        // asynchronous reset inside DATA of the second character of "007\n"
        qreg = 8'd7;
        begin
            logic [7:0] c;
            recv_char(0, c, s);
            chk("mid_c0", {24'd0, c}, 32'h30);
        end
        repeat (6) @(negedge clk);
        chk("mid_tx_low", tx4, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_tx", tx4, 1);
        chk("arst_busy", busy4, 0);
        chk("arst_ovf", ovf4, 0);
        qreg = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy4, 0);
        chk("post_rst_tx", tx4, 1);
        qreg = 8'd3; recv_value(0, 32'h3030330A, "v3", s);

        // CLKS_PER_BIT = 2
        qreg2 = 8'd7; k = cyc;
        @(negedge clk);
        chk("c2_busy_rise", busy2, 1);
        recv_value(1, 32'h3030370A, "c2_v7", s);
        chk("c2_start_cycle", s, k + 2);
        chk("c2_busy_last", busy2, 1);
        @(negedge clk);
        chk("c2_busy_fall", busy2, 0);
        chk("c2_frame_len", cyc - s, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
